// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the value producer / external BCD decoder and the seven-segment scan controller.
// The slave side is the scan controller; the master side is the producer, the decoder and the pins.
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value_in;
   logic                      lz_suppress;
   logic [3:0]                bcd_out;
   logic [6:0]                seg_in;
   logic [6:0]                seg_out;
   logic [NUM_DIGITS-1:0]     an_out;
   logic                      frame_done;

   modport master (
      output load, value_in, lz_suppress, seg_in,
      input  bcd_out, seg_out, an_out, frame_done
   );

   modport slave (
      input  load, value_in, lz_suppress, seg_in,
      output bcd_out, seg_out, an_out, frame_done
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Shares one external BCD decoder, double-buffers the displayed value, blanks between slots.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   seven_seg_scan_ctrl_if.slave bus
);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]   active_q, active_d;
   logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
   logic                         pend_q, pend_d;
   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic [6:0]                   seg_q, seg_d;
   logic                         fd_q, fd_d;

   logic                         last_slot, boundary, drive_en, zero_above;
   logic [NUM_DIGITS-1:0]        sup;

   assign bus.bcd_out    = active_q[idx_q];
   assign bus.an_out     = an_q;
   assign bus.seg_out    = seg_q;
   assign bus.frame_done = fd_q;

   // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
   always_comb begin
      sup        = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (active_q[k] == 4'h0);
         sup[k]     = bus.lz_suppress & zero_above & (k != 0);
      end
   end

   always_comb begin
      last_slot = (cnt_q == CNT_LAST);
      boundary  = last_slot && (idx_q == IDX_LAST);

      cnt_d = last_slot ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (last_slot)
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      state_d = state_q;
      case (state_q)
         BLANK:   if (BLANK_CYCLES == 0 || cnt_q == BLANK_END) state_d = DRIVE;
         DRIVE:   if (last_slot && BLANK_CYCLES != 0) state_d = BLANK;
         default: state_d = BLANK;
      endcase

      drive_en = (state_q == DRIVE) && !sup[idx_q];
      an_d     = drive_en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg_d    = drive_en ? bus.seg_in : 7'h7F;
      fd_d     = boundary;

      shadow_d = shadow_q;
      pend_d   = pend_q;
      active_d = active_q;
      if (bus.load) begin
         shadow_d = bus.value_in;
         pend_d   = 1'b1;
      end
      // The displayed value only changes between frames, so a scan never mixes two values.
      if (boundary) begin
         if (bus.load)
            active_d = bus.value_in;
         else if (pend_q)
            active_d = shadow_q;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         active_q <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         an_q     <= '1;
         seg_q    <= 7'h7F;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         fd_q     <= fd_d;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus random loads,
// compared every cycle against a frame/slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;
   localparam int N  = 4;
   localparam int R  = 8;
   localparam int B  = 2;
   localparam int FR = N * R;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'd0: dec = 7'b1000000;
         4'd1: dec = 7'b1111001;
         4'd2: dec = 7'b0100100;
         4'd3: dec = 7'b0110000;
         4'd4: dec = 7'b0011001;
         4'd5: dec = 7'b0010010;
         4'd6: dec = 7'b0000010;
         4'd7: dec = 7'b1111000;
         4'd8: dec = 7'b0000000;
         4'd9: dec = 7'b0010000;
         default: dec = 7'h7F;
      endcase
   endfunction

   assign bus.seg_in = dec(bus.bcd_out);

   int errors = 0;
   int checks = 0;

   // Reference model: k counts cycles since reset release.
   int          k;
   logic [15:0] act_m, sh_m;
   bit          pend_m;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   // Called at a negedge with this cycle's inputs already applied; returns at the next negedge.
   task automatic step();
      int         cnt, idx, fpos;
      bit         drv;
      logic [3:0] n;
      chk("an_out", {28'd0, bus.an_out}, {28'd0, exp_an});
      chk("seg_out", {25'd0, bus.seg_out}, {25'd0, exp_seg});
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
      cnt  = k % R;
      idx  = (k / R) % N;
      fpos = k % FR;
      n    = 4'((act_m >> (4 * idx)) & 16'hF);
      chk("bcd_out", {28'd0, bus.bcd_out}, {28'd0, n});
      drv     = (cnt >= B) && !(bus.lz_suppress && idx != 0 && (act_m >> (4 * idx)) == 16'd0);
      exp_an  = drv ? ~(4'b0001 << idx) : 4'hF;
      exp_seg = drv ? dec(n) : 7'h7F;
      exp_fd  = (fpos == FR - 1);
      if (fpos == FR - 1) begin
         if (bus.load) act_m = bus.value_in;
         else if (pend_m) act_m = sh_m;
         pend_m = 1'b0;
      end else if (bus.load) begin
         sh_m   = bus.value_in;
         pend_m = 1'b1;
      end
      k++;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic align(input int pos);
      while ((k % FR) != pos) step();
   endtask

   task automatic load_val(input logic [15:0] v);
      bus.value_in = v;
      bus.load     = 1'b1;
      step();
   endtask

   // Asserted at a negedge: outputs must drop at once, not at the next clock.
   task automatic do_reset();
      rst      = 1'b1;
      bus.load = 1'b0;
      #1;
      chk("rst_an", {28'd0, bus.an_out}, 32'hF);
      chk("rst_seg", {25'd0, bus.seg_out}, 32'h7F);
      chk("rst_fd", {31'd0, bus.frame_done}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      k = 0; act_m = '0; sh_m = '0; pend_m = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0; bus.value_in = '0; bus.lz_suppress = 1'b0;
      k = 0; act_m = '0; sh_m = '0; pend_m = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_fd = 1'b0;
      #2;
      do_reset();

      // Basic scan of 1234 with blanking and frame pulses
      load_val(16'h1234);
      run(3 * FR);

      // Leading-zero suppression
      bus.lz_suppress = 1'b1;
      load_val(16'h0050);
      run(2 * FR);
      load_val(16'h0000);
      run(2 * FR);
      bus.lz_suppress = 1'b0;

      // Mid-frame loads wait for the boundary; last load wins; boundary load commits at once
      align(R + 3);
      load_val(16'h9999);
      run(5);
      load_val(16'h8888);
      run(2 * FR);
      align(FR - 1);
      load_val(16'h1357);
      run(FR);

      // Invalid nibble counts as nonzero
      bus.lz_suppress = 1'b1;
      load_val(16'hA000);
      run(2 * FR);
      load_val(16'h0B00);
      run(2 * FR);
      bus.lz_suppress = 1'b0;

      // Reset during DRIVE of digit 2
      load_val(16'h4321);
      run(FR);
      align(2 * R + 5);
      do_reset();
      run(2 * FR);

      // Random loads and live lz_suppress changes
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) bus.lz_suppress = ~bus.lz_suppress;
         if ($urandom_range(0, 9) == 0) begin
            bus.value_in = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            bus.load     = 1'b1;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
